// File: rtl/reminder_scheduler.sv
// Hydration reminder scheduler: BCD minute countdown, alert with escalation,
// snooze, and a saturating BCD tally of acknowledged drinks.
//
// state  | meaning
// IDLE   | reminders disarmed, outputs quiet
// COUNT  | counting down the interval in BCD minutes
// ALERT  | reminder raised, waiting for ack/snooze, escalation timer running
// SNOOZE | counting down the snooze period, alert suppressed
module reminder_scheduler #(
  parameter int unsigned INTERVAL_MIN      = 45,
  parameter int unsigned SNOOZE_MIN        = 10,
  parameter int unsigned ALERT_TIMEOUT_MIN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       minTick,
  input  logic       enable,
  input  logic       ack,
  input  logic       snooze,
  input  logic       loadInterval,
  input  logic [7:0] intervalBcd,
  output logic       alert,
  output logic       escalate,
  output logic [7:0] minsLeftBcd,
  output logic [7:0] drinkCount,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_COUNT  = 2'b01,
    S_ALERT  = 2'b10,
    S_SNOOZE = 2'b11
  } state_e;

  localparam logic [3:0] INT_TENS = 4'(INTERVAL_MIN / 10);
  localparam logic [3:0] INT_ONES = 4'(INTERVAL_MIN % 10);
  localparam logic [3:0] SNZ_TENS = 4'(SNOOZE_MIN / 10);
  localparam logic [3:0] SNZ_ONES = 4'(SNOOZE_MIN % 10);
  localparam logic [7:0] INTERVAL_BCD = {INT_TENS, INT_ONES};
  localparam logic [7:0] SNOOZE_BCD   = {SNZ_TENS, SNZ_ONES};
  localparam logic [6:0] TIMEOUT      = 7'(ALERT_TIMEOUT_MIN);

  state_e     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] interval_q, interval_d;
  logic [7:0] drink_q, drink_d;
  logic [6:0] timer_q, timer_d;
  logic       escalate_q, escalate_d;
  logic       alert_q, alert_d;
  logic       load_ok;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) bcd_dec = {v[7:4] - 4'd1, 4'd9};
    else                bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v == 8'h99)          bcd_inc_sat = v;
    else if (v[3:0] == 4'd9) bcd_inc_sat = {v[7:4] + 4'd1, 4'd0};
    else                     bcd_inc_sat = {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign load_ok = loadInterval && (intervalBcd[7:4] <= 4'd9) &&
                   (intervalBcd[3:0] <= 4'd9) && (intervalBcd != 8'h00);

  // The reload paths read interval_q, so a load on the same edge is seen
  // only from the next reload onward.
  always_comb begin
    interval_d = load_ok ? intervalBcd : interval_q;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drink_d     = drink_q;
    timer_d     = timer_q;
    escalate_d  = escalate_q;

    if (!enable) begin
      state_d     = S_IDLE;
      remaining_d = 8'h00;
      timer_d     = 7'd0;
      escalate_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_COUNT;
          remaining_d = interval_q;
        end
        S_COUNT: begin
          if (ack) begin
            remaining_d = interval_q;
          end else if (snooze) begin
            state_d = S_COUNT;
          end else if (minTick) begin
            if (remaining_q == 8'h01) begin
              state_d     = S_ALERT;
              remaining_d = 8'h00;
              timer_d     = 7'd0;
              escalate_d  = 1'b0;
            end else begin
              remaining_d = bcd_dec(remaining_q);
            end
          end
        end
        S_ALERT: begin
          if (ack) begin
            state_d     = S_COUNT;
            remaining_d = interval_q;
            drink_d     = bcd_inc_sat(drink_q);
            timer_d     = 7'd0;
            escalate_d  = 1'b0;
          end else if (snooze) begin
            state_d     = S_SNOOZE;
            remaining_d = SNOOZE_BCD;
            timer_d     = 7'd0;
            escalate_d  = 1'b0;
          end else if (minTick) begin
            timer_d    = (timer_q < TIMEOUT) ? timer_q + 7'd1 : timer_q;
            escalate_d = (timer_d >= TIMEOUT);
          end
        end
        S_SNOOZE: begin
          if (ack) begin
            state_d     = S_COUNT;
            remaining_d = interval_q;
            drink_d     = bcd_inc_sat(drink_q);
          end else if (minTick) begin
            if (remaining_q == 8'h01) begin
              state_d     = S_ALERT;
              remaining_d = 8'h00;
              timer_d     = 7'd0;
              escalate_d  = 1'b0;
            end else begin
              remaining_d = bcd_dec(remaining_q);
            end
          end
        end
        default: begin
          state_d     = S_IDLE;
          remaining_d = 8'h00;
          timer_d     = 7'd0;
          escalate_d  = 1'b0;
        end
      endcase
    end

    alert_d = (state_d == S_ALERT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      remaining_q <= 8'h00;
      interval_q  <= INTERVAL_BCD;
      drink_q     <= 8'h00;
      timer_q     <= 7'd0;
      escalate_q  <= 1'b0;
      alert_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      interval_q  <= interval_d;
      drink_q     <= drink_d;
      timer_q     <= timer_d;
      escalate_q  <= escalate_d;
      alert_q     <= alert_d;
    end
  end

  assign state       = state_q;
  assign alert       = alert_q;
  assign escalate    = escalate_q;
  assign minsLeftBcd = remaining_q;
  assign drinkCount  = drink_q;

endmodule

// File: tb/tb_reminder_scheduler.sv
// Scoreboard bench for reminder_scheduler: a decimal reference model pushes
// expected outputs per driven cycle; a monitor pops and compares after each edge.
module tb_reminder_scheduler;

  logic       clk = 1'b0;
  logic       reset, minTick, enable, ack, snooze, loadInterval;
  logic [7:0] intervalBcd;
  logic       alert, escalate;
  logic [7:0] minsLeftBcd, drinkCount;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] exp_q[$];
  string       tag_q[$];
  string       cur_tag = "init";

  // reference model state, plain decimal
  int m_st = 0, m_rem = 0, m_int = 12, m_drink = 0, m_tmr = 0, m_esc = 0;

  reminder_scheduler #(
    .INTERVAL_MIN(12), .SNOOZE_MIN(10), .ALERT_TIMEOUT_MIN(5)
  ) dut (
    .clk(clk), .reset(reset), .minTick(minTick), .enable(enable), .ack(ack),
    .snooze(snooze), .loadInterval(loadInterval), .intervalBcd(intervalBcd),
    .alert(alert), .escalate(escalate), .minsLeftBcd(minsLeftBcd),
    .drinkCount(drinkCount), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_step(input logic r, e, a, s, t, l, input logic [7:0] v);
    int nint;
    if (!r) begin
      m_st = 0; m_rem = 0; m_int = 12; m_drink = 0; m_tmr = 0; m_esc = 0;
    end else begin
      nint = m_int;
      if (l && v[7:4] <= 9 && v[3:0] <= 9 && v != 0) nint = v[7:4] * 10 + v[3:0];
      if (!e) begin
        m_st = 0; m_rem = 0; m_esc = 0; m_tmr = 0;
      end else begin
        case (m_st)
          0: begin m_st = 1; m_rem = m_int; end
          1: begin
            if (a) m_rem = m_int;
            else if (!s && t) begin
              if (m_rem == 1) begin m_st = 2; m_rem = 0; m_tmr = 0; m_esc = 0; end
              else m_rem = m_rem - 1;
            end
          end
          2: begin
            if (a) begin
              m_st = 1; m_rem = m_int; m_esc = 0; m_tmr = 0;
              if (m_drink < 99) m_drink++;
            end else if (s) begin
              m_st = 3; m_rem = 10; m_esc = 0; m_tmr = 0;
            end else if (t) begin
              if (m_tmr < 5) m_tmr++;
              if (m_tmr >= 5) m_esc = 1;
            end
          end
          default: begin
            if (a) begin
              m_st = 1; m_rem = m_int;
              if (m_drink < 99) m_drink++;
            end else if (t) begin
              if (m_rem == 1) begin m_st = 2; m_rem = 0; m_tmr = 0; m_esc = 0; end
              else m_rem = m_rem - 1;
            end
          end
        endcase
      end
      m_int = nint;
    end
  endtask

  // Inputs change on the falling edge; the expectation for the following
  // rising edge is queued at the same moment.
  task automatic cyc(input logic r, e, a, s, t, l, input logic [7:0] v);
    @(negedge clk);
    reset = r; enable = e; ack = a; snooze = s; minTick = t;
    loadInterval = l; intervalBcd = v;
    model_step(r, e, a, s, t, l, v);
    exp_q.push_back({2'(m_st), (m_st == 2) ? 1'b1 : 1'b0, 1'(m_esc),
                     to_bcd(m_rem), to_bcd(m_drink)});
    tag_q.push_back(cur_tag);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 1, 0, 8'h00);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 0, 8'h00);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [19:0] e;
      string       tg;
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      check(tg, {12'h000, state, alert, escalate, minsLeftBcd, drinkCount},
            {12'h000, e});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    reset = 0; enable = 0; ack = 0; snooze = 0; minTick = 0;
    loadInterval = 0; intervalBcd = 8'h00;

    cur_tag = "reset";
    cyc(0, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 1, 0, 8'h00);
    cyc(0, 1, 0, 1, 1, 1, 8'h05);

    cur_tag = "disabled";
    cyc(1, 0, 0, 0, 1, 0, 8'h00);

    cur_tag = "countdown";
    idle_cyc(1);
    ticks(11);
    cur_tag = "to_alert";
    ticks(1);

    cur_tag = "escalate";
    ticks(4);
    ticks(1);
    ticks(3);
    cur_tag = "ack_alert";
    cyc(1, 1, 1, 0, 0, 0, 8'h00);

    cur_tag = "snooze_tick";
    ticks(12);
    cyc(1, 1, 0, 1, 1, 0, 8'h00);
    cyc(1, 1, 0, 1, 0, 0, 8'h00);
    ticks(10);
    cur_tag = "timer_rearm";
    ticks(4);
    cur_tag = "ack_snooze_same";
    cyc(1, 1, 1, 1, 0, 0, 8'h00);
    ticks(12);
    cyc(1, 1, 0, 1, 0, 0, 8'h00);
    cur_tag = "ack_in_snooze";
    cyc(1, 1, 1, 0, 0, 0, 8'h00);

    cur_tag = "bad_load";
    cyc(1, 1, 0, 0, 0, 1, 8'h3A);
    cyc(1, 1, 0, 0, 0, 1, 8'h00);
    cyc(1, 1, 0, 0, 0, 1, 8'hA1);
    cyc(1, 1, 1, 0, 0, 0, 8'h00);
    cur_tag = "load_mid_count";
    ticks(5);
    cyc(1, 1, 0, 0, 0, 1, 8'h30);
    ticks(2);
    cur_tag = "reload_new";
    cyc(1, 1, 1, 0, 0, 0, 8'h00);
    cur_tag = "load_with_reload";
    cyc(1, 1, 1, 0, 0, 1, 8'h20);
    cyc(1, 1, 1, 0, 0, 0, 8'h00);

    cur_tag = "disable_mid";
    ticks(3);
    cyc(1, 0, 1, 0, 1, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    cur_tag = "reenable";
    idle_cyc(2);

    cur_tag = "drink_fill";
    cyc(1, 1, 0, 0, 0, 1, 8'h01);
    cyc(1, 1, 1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 120 && m_drink < 99; k++) begin
      ticks(1);
      cyc(1, 1, 1, 0, 0, 0, 8'h00);
    end
    cur_tag = "drink_sat";
    ticks(1);
    cyc(1, 1, 1, 0, 0, 0, 8'h00);

    cur_tag = "reset_in_snooze";
    ticks(1);
    cyc(1, 1, 0, 1, 0, 0, 8'h00);
    ticks(1);
    cyc(0, 1, 1, 0, 1, 0, 8'h00);
    cur_tag = "interval_after_reset";
    idle_cyc(2);

    @(posedge clk);
    #2;
    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
